// File: rtl/lt_seq_ctrl.sv
// lt_seq_ctrl: bit-pair serial less-than/equal comparator, MSB pair first, start/busy/done handshake.
// Define LT_SEQ_EARLY_EXIT_EN to stop scanning at the first differing pair.
module lt_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_cmp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq
);
   localparam int NP = WIDTH / 2;
   localparam int IW = (NP > 1) ? $clog2(NP) : 1;
`ifdef LT_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             dec_q, dec_d, res_q, res_d;
   logic             busy_q, busy_d, done_q, done_d, lt_q, lt_d, eq_q, eq_d;
   logic [1:0]       pa, pb;
   logic             first, last;
   logic [WIDTH-1:0] flip;
   assign pa    = a_q[{idx_q, 1'b0} +: 2];
   assign pb    = b_q[{idx_q, 1'b0} +: 2];
   assign first = (pa != pb) && !dec_q;
   assign last  = (idx_q == '0) || (EARLY && first);
   // Inverting the sign bit maps two's-complement order onto unsigned order
   assign flip  = {signed_cmp, {(WIDTH-1){1'b0}}};
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      dec_d   = dec_q;
      res_d   = res_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      lt_d    = lt_q;
      eq_d    = eq_q;
      if (state_q == RUN) begin
         idx_d = idx_q - 1'b1;
         if (first) begin
            dec_d = 1'b1;
            res_d = pa < pb;
         end
         if (last) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            lt_d    = first ? (pa < pb) : (dec_q & res_q);
            eq_d    = !first && !dec_q;
         end
      end else if (start) begin
         state_d = RUN;
         busy_d  = 1'b1;
         a_d     = a ^ flip;
         b_d     = b ^ flip;
         idx_d   = IW'(NP - 1);
         dec_d   = 1'b0;
      end else begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         dec_q   <= 1'b0;
         res_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         dec_q   <= dec_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
endmodule

// File: tb/tb_lt_seq_ctrl.sv
// tb_lt_seq_ctrl: directed vectors with a queue scoreboard checking lt/eq, latency, busy length and done width.
module tb_lt_seq_ctrl;
`ifdef LT_SEQ_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif
   logic        clk, rst_n, start, signed_cmp, busy, done, lt, eq;
   logic [31:0] a, b;
   int          checks = 0, fails = 0, cyc = 0, busy_cnt = 0;
   logic        prev_done = 1'b0;
   typedef struct {logic lt; logic eq; int n; int t;} exp_t;
   exp_t        sb[$];
   lt_seq_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_cmp(signed_cmp),
      .a(a), .b(b), .busy(busy), .done(done), .lt(lt), .eq(eq)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, req, $time);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) busy_cnt = 0;
      else begin
         if (busy) busy_cnt++;
         if (done) begin
            chk("done_width", int'(prev_done), 0);
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               chk("lt", int'(lt), int'(e.lt));
               chk("eq", int'(eq), int'(e.eq));
               chk("latency", cyc - e.t, e.n);
               chk("busy_cycles", busy_cnt, e.n);
            end
            busy_cnt = 0;
         end
      end
      prev_done = done;
   end
   // Caller sits at a negedge; returns just after the accepting edge E0
   task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic s,
                        input logic elt, input logic eeq, input int n_early, input bit push);
      exp_t e;
      a = va;
      b = vb;
      signed_cmp = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 32'hx;
      b = 32'hx;
      e.lt = elt;
      e.eq = eeq;
      e.n  = EE ? n_early : 16;
      e.t  = cyc;
      if (push) sb.push_back(e);
   endtask
   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      signed_cmp = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_lt", int'(lt), 0);
      chk("rst_eq", int'(eq), 0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 16, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h80000000, 32'h1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h80000000, 32'h1, 1'b1, 1'b1, 1'b0, 1, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 16, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 16, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h3, 32'h9, 1'b0, 1'b1, 1'b0, 15, 1'b1);
      repeat (3) @(negedge clk);
      a = 32'h9;
      b = 32'h3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      issue(32'h5, 32'h7, 1'b0, 1'b0, 1'b0, 16, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_lt", int'(lt), 0);
      chk("abort_eq", int'(eq), 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1, 1'b1);
      wait_done();
      @(negedge clk);
      issue(32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 16, 1'b1);
      wait_done();
      issue(32'h2, 32'h2, 1'b0, 1'b0, 1'b1, 16, 1'b1);
      chk("b2b_accept_busy", int'(busy), 1);
      repeat (5) @(negedge clk);
      chk("b2b_hold_lt", int'(lt), 1);
      wait_done();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
